mlt_dispatch: RTL

Operand dispatcher and result collector placed directly in front of the repeated-addition multiplier top. It accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, drives the multiplier's start/operand inputs one job at a time, waits for done, and returns each 16-bit product on a valid/ready output stream in issue order. It also short-circuits zero operands and traps a hung multiplier with a timeout.

---
 rtl/mlt_pkg.sv | 14 +
 rtl/mlt_op_fifo.sv | 54 +++++
 rtl/mlt_dispatch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mlt_pkg.sv
// rtl/mlt_pkg.sv - shared widths, timeout default and FSM encoding for the multiplier dispatcher
package mlt_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 70000;
  localparam int TIMER_W     = 17;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

endpackage

// File: rtl/mlt_op_fifo.sv
// rtl/mlt_op_fifo.sv - operand-pair FIFO with pointer-plus-count full/empty
module mlt_op_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mlt_dispatch.sv
// rtl/mlt_dispatch.sv - feeds operand pairs to the repeated-addition multiplier and returns products in order
module mlt_dispatch
  import mlt_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_ain,
  output logic [WIDTH-1:0] mul_bin,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             fault
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [2:0]         state;
  logic [TIMER_W-1:0] timer;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               slot_free;
  logic               head_zero;
  logic               done_load;

  assign head_a    = head[2*WIDTH-1:WIDTH];
  assign head_b    = head[WIDTH-1:0];
  assign head_zero = (head_a == '0) | (head_b == '0);

  assign fault     = (state == S_FAULT);
  assign in_ready  = !fifo_full & !fault;
  assign push      = in_valid & in_ready;
  // The output slot is free if empty or being drained on this same edge.
  assign slot_free = !out_valid | out_ready;
  assign pop       = (state == S_IDLE) & !fifo_empty & slot_free;
  assign done_load = (state == S_WAIT) & mul_done;
  assign mul_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE) | !fifo_empty;

  mlt_op_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Job sequencing; ARM skips one cycle so a done left over from the previous job is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop && !head_zero) state <= S_ISSUE;
        end
        S_ISSUE: state <= S_ARM;
        S_ARM: begin
          state <= S_WAIT;
          timer <= '0;
        end
        S_WAIT: begin
          if (mul_done) begin
            state <= S_IDLE;
          end else if (timer == TIMER_LAST) begin
            state <= S_FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operands are captured on pop and held until the next non-trivial job is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_ain <= '0;
      mul_bin <= '0;
    end else if (pop && !head_zero) begin
      mul_ain <= head_a;
      mul_bin <= head_b;
    end
  end

  // Single-entry result slot: loaded by zero short-circuit or multiplier done, cleared on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop && head_zero) begin
      out_valid <= 1'b1;
      out_data  <= '0;
    end else if (done_load) begin
      out_valid <= 1'b1;
      out_data  <= mul_result;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
